// File: rtl/alu_pkg.sv
// Shared constants for the LEGv8 ALU issue sequencer: ALU opcodes, instruction
// opcode fields and the sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_ORR   = 3'b001;
  localparam logic [2:0] ALU_NOTA  = 3'b010;
  localparam logic [2:0] ALU_PASSA = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_ADD   = 3'b101;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_MOVK  = 3'b111;

  // Field widths follow the instruction format: R/D = 11, I = 10, IM = 9, CB = 8, B = 6
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [8:0]  OP_MOVK = 9'b111100101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXEC    = 2'd2,
    ST_RESOLVE = 2'd3
  } state_t;

endpackage

// File: rtl/legv8_opdecode.sv
// Combinational LEGv8 opcode decoder: top 11 instruction bits to ALU controls,
// datapath strobes and branch-class flags.
module legv8_opdecode
  import alu_pkg::*;
(
  input  logic [10:0] i_op,
  output logic [2:0]  o_alu_opcode,
  output logic        o_alu_src,
  output logic        o_reg2loc,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_reg_write,
  output logic        o_is_cbz,
  output logic        o_is_cbnz,
  output logic        o_is_b,
  output logic        o_illegal
);

  always_comb begin
    o_alu_opcode = ALU_AND;
    o_alu_src    = 1'b0;
    o_reg2loc    = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_reg_write  = 1'b0;
    o_is_cbz     = 1'b0;
    o_is_cbnz    = 1'b0;
    o_is_b       = 1'b0;
    o_illegal    = 1'b0;
    // Unconditional branch wins, then compare-and-branch, then the ALU table
    if (i_op[10:5] == OP_B) begin
      o_is_b = 1'b1;
    end else if (i_op[10:3] == OP_CBZ || i_op[10:3] == OP_CBNZ) begin
      o_alu_opcode = ALU_PASSB;
      o_reg2loc    = 1'b1;
      o_is_cbz     = (i_op[10:3] == OP_CBZ);
      o_is_cbnz    = (i_op[10:3] == OP_CBNZ);
    end else if (i_op == OP_ADD) begin
      o_alu_opcode = ALU_ADD;
      o_reg_write  = 1'b1;
    end else if (i_op == OP_SUB) begin
      o_alu_opcode = ALU_SUB;
      o_reg_write  = 1'b1;
    end else if (i_op == OP_AND) begin
      o_alu_opcode = ALU_AND;
      o_reg_write  = 1'b1;
    end else if (i_op == OP_ORR) begin
      o_alu_opcode = ALU_ORR;
      o_reg_write  = 1'b1;
    end else if (i_op == OP_LDUR) begin
      o_alu_opcode = ALU_ADD;
      o_alu_src    = 1'b1;
      o_mem_read   = 1'b1;
      o_reg_write  = 1'b1;
    end else if (i_op == OP_STUR) begin
      o_alu_opcode = ALU_ADD;
      o_alu_src    = 1'b1;
      o_mem_write  = 1'b1;
      o_reg2loc    = 1'b1;
    end else if (i_op[10:1] == OP_ADDI) begin
      o_alu_opcode = ALU_ADD;
      o_alu_src    = 1'b1;
      o_reg_write  = 1'b1;
    end else if (i_op[10:1] == OP_SUBI) begin
      o_alu_opcode = ALU_SUB;
      o_alu_src    = 1'b1;
      o_reg_write  = 1'b1;
    end else if (i_op[10:2] == OP_MOVK) begin
      o_alu_opcode = ALU_MOVK;
      o_alu_src    = 1'b1;
      o_reg_write  = 1'b1;
    end else begin
      o_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue sequencer: accepts one LEGv8 instruction, holds ALU controls
// for EXEC_CYCLES, then resolves strobes and branch outcome in a single cycle.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int REGSIZE     = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  output logic               instr_ready,
  output logic [2:0]         alu_opcode,
  output logic               alu_src,
  output logic               reg2loc,
  input  logic               alu_nz,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               br_taken,
  output logic [REGSIZE-1:0] br_offset,
  output logic               illegal,
  output logic               done
);

  if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_exec_range
    $error("alu_issue_ctrl: EXEC_CYCLES must be in 1..15");
  end
  if (REGSIZE < 28) begin : g_regsize_range
    $error("alu_issue_ctrl: REGSIZE must hold a 28-bit branch offset");
  end

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_instr;
  logic [3:0]         r_cnt;
  logic [2:0]         r_alu_opcode;
  logic               r_alu_src, r_reg2loc;
  logic               r_mem_read, r_mem_write, r_reg_write;
  logic               r_is_cbz, r_is_cbnz, r_is_b, r_illegal;
  logic [REGSIZE-1:0] r_br_offset;

  logic [2:0]         w_alu_opcode;
  logic               w_alu_src, w_reg2loc;
  logic               w_mem_read, w_mem_write, w_reg_write;
  logic               w_is_cbz, w_is_cbnz, w_is_b, w_illegal;
  logic [REGSIZE-1:0] w_cb_off, w_b_off;

  legv8_opdecode u_opdecode (
    .i_op         (r_instr[31:21]),
    .o_alu_opcode (w_alu_opcode),
    .o_alu_src    (w_alu_src),
    .o_reg2loc    (w_reg2loc),
    .o_mem_read   (w_mem_read),
    .o_mem_write  (w_mem_write),
    .o_reg_write  (w_reg_write),
    .o_is_cbz     (w_is_cbz),
    .o_is_cbnz    (w_is_cbnz),
    .o_is_b       (w_is_b),
    .o_illegal    (w_illegal)
  );

  // Word offsets become byte offsets, sign-extended to the full datapath width
  assign w_cb_off = {{(REGSIZE-21){r_instr[23]}}, r_instr[23:5], 2'b00};
  assign w_b_off  = {{(REGSIZE-28){r_instr[25]}}, r_instr[25:0], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_instr      <= '0;
      r_cnt        <= '0;
      r_alu_opcode <= '0;
      r_alu_src    <= 1'b0;
      r_reg2loc    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_is_cbz     <= 1'b0;
      r_is_cbnz    <= 1'b0;
      r_is_b       <= 1'b0;
      r_illegal    <= 1'b0;
      r_br_offset  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) r_instr <= instr;
        end
        ST_DECODE: begin
          r_cnt        <= CNT_INIT;
          r_alu_opcode <= w_alu_opcode;
          r_alu_src    <= w_alu_src;
          r_reg2loc    <= w_reg2loc;
          r_mem_read   <= w_mem_read;
          r_mem_write  <= w_mem_write;
          r_reg_write  <= w_reg_write;
          r_is_cbz     <= w_is_cbz;
          r_is_cbnz    <= w_is_cbnz;
          r_is_b       <= w_is_b;
          r_illegal    <= w_illegal;
          if (w_is_b)                     r_br_offset <= w_b_off;
          else if (w_is_cbz || w_is_cbnz) r_br_offset <= w_cb_off;
          else                            r_br_offset <= '0;
        end
        ST_EXEC: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    instr_ready = 1'b0;
    alu_opcode  = '0;
    alu_src     = 1'b0;
    reg2loc     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    br_taken    = 1'b0;
    br_offset   = '0;
    illegal     = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Ready is withheld while reset is held so the handshake cannot race its release
        instr_ready = ~reset;
        if (instr_valid) w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        alu_opcode = r_alu_opcode;
        alu_src    = r_alu_src;
        reg2loc    = r_reg2loc;
        if (r_cnt == 4'd0) w_state_nxt = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        alu_opcode  = r_alu_opcode;
        alu_src     = r_alu_src;
        reg2loc     = r_reg2loc;
        mem_read    = r_mem_read;
        mem_write   = r_mem_write;
        reg_write   = r_reg_write;
        br_taken    = r_is_b | (r_is_cbz & ~alu_nz) | (r_is_cbnz & alu_nz);
        br_offset   = r_br_offset;
        illegal     = r_illegal;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a driver pushes accepted instructions, a
// monitor checks timing and outputs against a table-driven instruction model.
module tb_alu_issue_ctrl;

  localparam int EXEC = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [2:0]  alu_opcode;
  logic        alu_src, reg2loc, alu_nz;
  logic        mem_read, mem_write, reg_write, br_taken, illegal, done;
  logic [63:0] br_offset;

  alu_issue_ctrl #(.EXEC_CYCLES(EXEC), .REGSIZE(64)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_opcode(alu_opcode), .alu_src(alu_src),
    .reg2loc(reg2loc), .alu_nz(alu_nz), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .br_taken(br_taken), .br_offset(br_offset),
    .illegal(illegal), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [2:0]  op;
    logic        src, r2l, mr, mw, rw;
  } ent_t;

  typedef struct {
    logic [2:0]  op;
    logic        src, r2l, mr, mw, rw, bt, ill;
    logic [63:0] off;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    int          hs;
  } item_t;

  ent_t  tbl[9];
  item_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    nz_mode = 2;
  logic  prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction semantics as mask/match table plus branch forms
  function automatic exp_t model(input logic [31:0] w, input logic nz);
    exp_t e;
    e = '{op: 3'd0, src: 1'b0, r2l: 1'b0, mr: 1'b0, mw: 1'b0, rw: 1'b0, bt: 1'b0, ill: 1'b0, off: 64'd0};
    if (w[31:26] == 6'b000101) begin
      e.bt  = 1'b1;
      e.off = 64'(longint'($signed(w[25:0])) * 4);
    end else if (w[31:25] == 7'b1011010) begin
      e.op  = 3'd4;
      e.r2l = 1'b1;
      e.bt  = w[24] ? nz : !nz;
      e.off = 64'(longint'($signed(w[23:5])) * 4);
    end else begin
      e.ill = 1'b1;
      for (int i = 0; i < 9; i++) begin
        if ((w & tbl[i].mask) == tbl[i].match) begin
          e.ill = 1'b0;
          e.op  = tbl[i].op;
          e.src = tbl[i].src;
          e.r2l = tbl[i].r2l;
          e.mr  = tbl[i].mr;
          e.mw  = tbl[i].mw;
          e.rw  = tbl[i].rw;
          break;
        end
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9)       return (r & ~tbl[k].mask) | tbl[k].match;
    else if (k == 9) return {6'b000101, r[25:0]};
    else if (k == 10) return {7'b1011010, r[24:0]};
    else             return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // ALU status stub: forced or random, changed only on the rising edge
  always @(posedge clk) begin
    if (nz_mode == 2) alu_nz = 1'($urandom_range(0, 1));
    else              alu_nz = (nz_mode == 1);
  end

  always @(negedge clk) begin
    item_t it;
    exp_t  e;
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("ready_after_done", 64'(instr_ready), 64'd1);
      prev_done = done;
      if (done) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, required no done (nothing pending)");
        end else begin
          it = q.pop_front();
          e  = model(it.w, alu_nz);
          chk("latency",    64'(cyc - it.hs), 64'(EXEC + 1));
          chk("alu_opcode", 64'(alu_opcode), 64'(e.op));
          chk("alu_src",    64'(alu_src),    64'(e.src));
          chk("reg2loc",    64'(reg2loc),    64'(e.r2l));
          chk("strobes",    64'({mem_read, mem_write, reg_write}), 64'({e.mr, e.mw, e.rw}));
          chk("br_taken",   64'(br_taken),   64'(e.bt));
          chk("br_offset",  br_offset,       e.off);
          chk("illegal",    64'(illegal),    64'(e.ill));
          chk("ready_in_resolve", 64'(instr_ready), 64'd0);
        end
      end else begin
        chk("quiet_strobes", 64'({mem_read, mem_write, reg_write, br_taken, illegal}), 64'd0);
        if (q.size() != 0) begin
          it = q[0];
          e  = model(it.w, 1'b0);
          if (cyc == it.hs)
            chk("decode_ctrl_zero", 64'({alu_opcode, alu_src, reg2loc}), 64'd0);
          else if (cyc > it.hs && cyc <= it.hs + EXEC)
            chk("exec_ctrl", 64'({alu_opcode, alu_src, reg2loc}), 64'({e.op, e.src, e.r2l}));
        end
        if (instr_ready)
          chk("idle_ctrl_zero", 64'({alu_opcode, alu_src, reg2loc}) | br_offset, 64'd0);
      end
    end
  end

  task automatic issue(input logic [31:0] w, input int mode, input int gap, input bit push);
    int t;
    if (gap > 0) begin
      instr_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    instr       = w;
    instr_valid = 1'b1;
    t = 0;
    while (!instr_ready) begin
      @(negedge clk);
      t++;
      if (t > 60) begin
        chk("accept_timeout", 64'(instr_ready), 64'd1);
        return;
      end
    end
    if (push) q.push_back('{w: w, hs: cyc + 1});
    nz_mode = mode;
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{32'hFFE00000, 32'h8B000000, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // ADD
    tbl[1] = '{32'hFFE00000, 32'hCB000000, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // SUB
    tbl[2] = '{32'hFFE00000, 32'h8A000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // AND
    tbl[3] = '{32'hFFE00000, 32'hAA000000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // ORR
    tbl[4] = '{32'hFFC00000, 32'h91000000, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // ADDI
    tbl[5] = '{32'hFFC00000, 32'hD1000000, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // SUBI
    tbl[6] = '{32'hFFE00000, 32'hF8400000, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}; // LDUR
    tbl[7] = '{32'hFFE00000, 32'hF8000000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // STUR
    tbl[8] = '{32'hFF800000, 32'hF2800000, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // MOVK

    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(instr_ready), 64'd0);
    chk("rst_outputs", 64'({alu_opcode, alu_src, reg2loc, mem_read, mem_write, reg_write,
                            br_taken, illegal, done}) | br_offset, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(instr_ready), 64'd1);

    issue(32'h8B030041, 2, 0, 1'b1); // ADD X1,X2,X3
    issue(32'hB4000045, 0, 2, 1'b1); // CBZ X5,+8, zero -> taken
    issue(32'hB4000045, 1, 0, 1'b1); // CBZ, non-zero -> not taken
    issue(32'hB5FFFFE5, 1, 0, 1'b1); // CBNZ -4, non-zero -> taken
    issue(32'h17FFFFFF, 2, 1, 1'b1); // B -4
    issue(32'hF8408020, 2, 0, 1'b1); // LDUR X0,[X1,#8]
    issue(32'hF8008020, 2, 0, 1'b1); // STUR
    issue(32'hFFFFFFFF, 2, 0, 1'b1); // illegal, valid stays high
    issue(32'hF2800041, 2, 0, 1'b1); // MOVK

    for (int i = 0; i < 150; i++)
      issue(rand_instr(), 2, $urandom_range(0, 2), 1'b1);

    // Abort an instruction during EXEC; nothing may complete
    issue(32'h8B030041, 2, 1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_outputs", 64'({instr_ready, alu_opcode, alu_src, reg2loc, mem_read, mem_write,
                              reg_write, br_taken, illegal, done}) | br_offset, 64'd0);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", 64'({instr_ready, done}), 64'b10);

    issue(32'hCB030041, 2, 0, 1'b1); // SUB after recovery
    issue(32'h91002041, 2, 0, 1'b1); // ADDI
    instr_valid = 1'b0;

    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
